// File: rtl/ahb_dbg_arbiter.sv
// Two-master AHB-Lite arbiter merging the UART debugger and core buses onto one master port.
// Define DBG_ARB_WAIT_CNT_EN to add the dbg_wait_cycles stall counter output.
module ahb_dbg_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] C_HADDR,
    input  logic [31:0] C_HWDATA,
    input  logic        C_HWRITE,
    input  logic [2:0]  C_HSIZE,
    input  logic [2:0]  C_HBURST,
    input  logic [1:0]  C_HTRANS,
    output logic        C_HREADY,
    output logic [31:0] C_HRDATA,
    input  logic [31:0] D_HADDR,
    input  logic [31:0] D_HWDATA,
    input  logic        D_HWRITE,
    input  logic [2:0]  D_HSIZE,
    input  logic [2:0]  D_HBURST,
    input  logic [1:0]  D_HTRANS,
    output logic        D_HREADY,
    output logic [31:0] D_HRDATA,
    output logic [31:0] HADDR,
    output logic [31:0] HWDATA,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [1:0]  HTRANS,
    input  logic        HREADY,
    input  logic [31:0] HRDATA
`ifdef DBG_ARB_WAIT_CNT_EN
    ,
    output logic [15:0] dbg_wait_cycles
`endif
);

    typedef enum logic {GNT_CORE = 1'b0, GNT_DBG = 1'b1} gnt_e;

    typedef struct packed {
        logic [31:0] haddr;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [2:0]  hburst;
        logic [1:0]  htrans;
    } ahb_ap_t;

    gnt_e    state;
    logic    dp_dbg;
    ahb_ap_t core_ap, dbg_ap, bus_ap;

    // Switching only when the current owner is IDLE and the bus is ready keeps
    // every issued address phase intact; BUSY blocks the switch like a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= GNT_CORE;
            dp_dbg <= 1'b0;
        end else begin
            if (HREADY)
                dp_dbg <= (state == GNT_DBG);
            case (state)
                GNT_CORE:
                    if (D_HTRANS[1] && C_HTRANS == 2'b00 && HREADY)
                        state <= GNT_DBG;
                GNT_DBG:
                    if (D_HTRANS == 2'b00 && C_HTRANS[1] && HREADY)
                        state <= GNT_CORE;
                default: state <= GNT_CORE;
            endcase
        end
    end

    assign core_ap = '{haddr: C_HADDR, hwrite: C_HWRITE, hsize: C_HSIZE,
                       hburst: C_HBURST, htrans: C_HTRANS};
    assign dbg_ap  = '{haddr: D_HADDR, hwrite: D_HWRITE, hsize: D_HSIZE,
                       hburst: D_HBURST, htrans: D_HTRANS};
    assign bus_ap  = (state == GNT_DBG) ? dbg_ap : core_ap;

    assign HADDR  = bus_ap.haddr;
    assign HWRITE = bus_ap.hwrite;
    assign HSIZE  = bus_ap.hsize;
    assign HBURST = bus_ap.hburst;
    assign HTRANS = bus_ap.htrans;
    assign HWDATA = dp_dbg ? D_HWDATA : C_HWDATA;

    // A master sees HREADY while it owns either the address or the data phase;
    // the other master is stalled so it keeps its address phase on its own bus.
    assign C_HREADY = HREADY & ((state == GNT_CORE) | ~dp_dbg);
    assign D_HREADY = HREADY & ((state == GNT_DBG)  |  dp_dbg);
    assign C_HRDATA = HRDATA;
    assign D_HRDATA = HRDATA;

`ifdef DBG_ARB_WAIT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dbg_wait_cycles <= 16'h0000;
        else if (D_HTRANS[1] && state == GNT_CORE && dbg_wait_cycles != 16'hFFFF)
            dbg_wait_cycles <= dbg_wait_cycles + 16'd1;
    end
`endif

endmodule

// File: tb/tb_ahb_dbg_arbiter.sv
// Self-checking bench for ahb_dbg_arbiter: directed scenarios plus random traffic vs. a bus-ownership model.
module tb_ahb_dbg_arbiter;

    localparam int CORE = 0;
    localparam int DBG  = 1;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    logic        clk, rst;
    logic [31:0] C_HADDR, C_HWDATA, C_HRDATA, D_HADDR, D_HWDATA, D_HRDATA;
    logic        C_HWRITE, C_HREADY, D_HWRITE, D_HREADY;
    logic [2:0]  C_HSIZE, C_HBURST, D_HSIZE, D_HBURST;
    logic [1:0]  C_HTRANS, D_HTRANS;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic        HWRITE, HREADY;
    logic [2:0]  HSIZE, HBURST;
    logic [1:0]  HTRANS;
`ifdef DBG_ARB_WAIT_CNT_EN
    logic [15:0] dbg_wait_cycles;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the address phase, who owns the data phase,
    // and how many cycles the debugger has been kept waiting.
    int own    = CORE;
    int dp_own = CORE;
    int m_cnt  = 0;

    ahb_dbg_arbiter dut (
        .clk(clk), .rst(rst),
        .C_HADDR(C_HADDR), .C_HWDATA(C_HWDATA), .C_HWRITE(C_HWRITE), .C_HSIZE(C_HSIZE),
        .C_HBURST(C_HBURST), .C_HTRANS(C_HTRANS), .C_HREADY(C_HREADY), .C_HRDATA(C_HRDATA),
        .D_HADDR(D_HADDR), .D_HWDATA(D_HWDATA), .D_HWRITE(D_HWRITE), .D_HSIZE(D_HSIZE),
        .D_HBURST(D_HBURST), .D_HTRANS(D_HTRANS), .D_HREADY(D_HREADY), .D_HRDATA(D_HRDATA),
        .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HTRANS(HTRANS), .HREADY(HREADY), .HRDATA(HRDATA)
`ifdef DBG_ARB_WAIT_CNT_EN
        , .dbg_wait_cycles(dbg_wait_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, let it settle, compare every output to the model.
    task automatic drive(input logic [1:0] ct, input logic [1:0] dt, input logic hr,
                         input logic [31:0] ca, input logic [31:0] da,
                         input logic [31:0] cw, input logic [31:0] dw);
        logic c_sees, d_sees;
        C_HTRANS = ct;  D_HTRANS = dt;  HREADY = hr;
        C_HADDR  = ca;  D_HADDR  = da;
        C_HWDATA = cw;  D_HWDATA = dw;
        C_HWRITE = 1'($urandom());  D_HWRITE = 1'($urandom());
        C_HSIZE  = 3'($urandom());  D_HSIZE  = 3'($urandom());
        C_HBURST = 3'($urandom());  D_HBURST = 3'($urandom());
        HRDATA   = $urandom();
        #3;
        chk("haddr",  HADDR,  own == DBG ? D_HADDR  : C_HADDR);
        chk("htrans", 32'(HTRANS), own == DBG ? 32'(D_HTRANS) : 32'(C_HTRANS));
        chk("hwrite", 32'(HWRITE), own == DBG ? 32'(D_HWRITE) : 32'(C_HWRITE));
        chk("hsize",  32'(HSIZE),  own == DBG ? 32'(D_HSIZE)  : 32'(C_HSIZE));
        chk("hburst", 32'(HBURST), own == DBG ? 32'(D_HBURST) : 32'(C_HBURST));
        chk("hwdata", HWDATA, dp_own == DBG ? D_HWDATA : C_HWDATA);
        c_sees = (own == CORE) || (dp_own == CORE);
        d_sees = (own == DBG)  || (dp_own == DBG);
        chk("c_hready", 32'(C_HREADY), c_sees ? 32'(HREADY) : 32'd0);
        chk("d_hready", 32'(D_HREADY), d_sees ? 32'(HREADY) : 32'd0);
        chk("c_hrdata", C_HRDATA, HRDATA);
        chk("d_hrdata", D_HRDATA, HRDATA);
`ifdef DBG_ARB_WAIT_CNT_EN
        chk("wait_cnt", 32'(dbg_wait_cycles), 32'(m_cnt));
`endif
    endtask

    // Clock edge: ownership moves only when the current owner is idle and the bus is ready.
    task automatic tick();
        int nxt;
        @(posedge clk);
        nxt = own;
        if (HREADY) begin
            if (own == CORE && D_HTRANS[1] && C_HTRANS == T_IDLE) nxt = DBG;
            if (own == DBG && C_HTRANS[1] && D_HTRANS == T_IDLE)  nxt = CORE;
        end
        if (own == CORE && D_HTRANS[1] && m_cnt < 65535) m_cnt++;
        if (HREADY) dp_own = own;
        own = nxt;
        #1;
    endtask

    // Assert reset mid-cycle; its effect must be immediate.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_d_hready", 32'(D_HREADY), 32'd0);
        chk("rst_c_hready", 32'(C_HREADY), 32'(HREADY));
        chk("rst_haddr",    HADDR, C_HADDR);
        chk("rst_htrans",   32'(HTRANS), 32'(C_HTRANS));
        chk("rst_hwdata",   HWDATA, C_HWDATA);
`ifdef DBG_ARB_WAIT_CNT_EN
        chk("rst_wait_cnt", 32'(dbg_wait_cycles), 32'd0);
`endif
        own = CORE;  dp_own = CORE;  m_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] ct, dt;
        logic [31:0] hold_w;
        rst = 1'b1;
        C_HTRANS = T_IDLE;  D_HTRANS = T_NSEQ;  HREADY = 1'b1;
        C_HADDR = 32'h0000_0abc;  D_HADDR = 32'h2000_0000;
        C_HWDATA = 32'h1111_1111; D_HWDATA = 32'h2222_2222;
        C_HWRITE = 1'b0; D_HWRITE = 1'b1; C_HSIZE = 3'd2; D_HSIZE = 3'd2;
        C_HBURST = 3'd0; D_HBURST = 3'd0; HRDATA = 32'h0;
        #12;
        chk("init_d_hready", 32'(D_HREADY), 32'd0);
        chk("init_c_hready", 32'(C_HREADY), 32'd1);
        chk("init_haddr",    HADDR, 32'h0000_0abc);
        chk("init_hwdata",   HWDATA, 32'h1111_1111);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Core-only single write, debugger idle.
        drive(T_NSEQ, T_IDLE, 1'b1, 32'h0000_1000, 32'h0, $urandom(), $urandom());
        chk("core_haddr", HADDR, 32'h0000_1000);
        tick();
        drive(T_IDLE, T_IDLE, 1'b1, 32'h0, 32'h0, 32'hDEAD_BEEF, $urandom());
        chk("core_hwdata", HWDATA, 32'hDEAD_BEEF);
        chk("core_d_hready", 32'(D_HREADY), 32'd0);
        tick();

        // Core INCR4 burst; debugger requests from the second beat.
        drive(T_NSEQ, T_IDLE, 1'b1, 32'h0000_1000, 32'h0, $urandom(), $urandom()); tick();
        drive(T_SEQ, T_NSEQ, 1'b1, 32'h0000_1004, 32'h2000_0000, $urandom(), $urandom());
        chk("burst_d_hready", 32'(D_HREADY), 32'd0);
        tick();
        drive(T_SEQ, T_NSEQ, 1'b1, 32'h0000_1008, 32'h2000_0000, $urandom(), $urandom()); tick();
        drive(T_SEQ, T_NSEQ, 1'b1, 32'h0000_100C, 32'h2000_0000, $urandom(), $urandom()); tick();
        drive(T_IDLE, T_NSEQ, 1'b1, 32'h0, 32'h2000_0000, $urandom(), $urandom()); tick();
        drive(T_IDLE, T_NSEQ, 1'b1, 32'h0, 32'h2000_0000, $urandom(), $urandom());
        chk("sw_htrans", 32'(HTRANS), 32'(T_NSEQ));
        chk("sw_haddr",  HADDR, 32'h2000_0000);
`ifdef DBG_ARB_WAIT_CNT_EN
        chk("burst_wait_cnt", 32'(dbg_wait_cycles), 32'd4);
`endif
        tick();
        drive(T_IDLE, T_IDLE, 1'b1, 32'h0, 32'h0, $urandom(), $urandom());
        chk("dbg_rd_hready", 32'(D_HREADY), 32'd1);
        chk("dbg_rdata", D_HRDATA, HRDATA);
        tick();

        // Debugger write with a two-cycle slave wait state; core waiting to issue.
        hold_w = 32'hCAFE_F00D;
        drive(T_IDLE, T_NSEQ, 1'b1, 32'h0, 32'h2000_0010, $urandom(), $urandom()); tick();
        for (int i = 0; i < 2; i++) begin
            drive(T_NSEQ, T_IDLE, 1'b0, 32'h0000_1100, 32'h0, $urandom(), hold_w);
            chk("ws_hwdata", HWDATA, hold_w);
            chk("ws_htrans", 32'(HTRANS), 32'(T_IDLE));
            tick();
        end
        drive(T_NSEQ, T_IDLE, 1'b1, 32'h0000_1100, 32'h0, $urandom(), hold_w);
        chk("ws_hwdata_rdy", HWDATA, hold_w);
        tick();
        drive(T_NSEQ, T_IDLE, 1'b1, 32'h0000_1100, 32'h0, $urandom(), $urandom());
        chk("ws_core_haddr",  HADDR, 32'h0000_1100);
        chk("ws_core_htrans", 32'(HTRANS), 32'(T_NSEQ));
        tick();

        // Grant parked on the debugger, then both request together.
        drive(T_IDLE, T_NSEQ, 1'b1, 32'h0, 32'h2000_0020, $urandom(), $urandom()); tick();
        drive(T_IDLE, T_IDLE, 1'b1, 32'h0, 32'h0, $urandom(), $urandom()); tick();
        drive(T_NSEQ, T_NSEQ, 1'b1, 32'h0000_1200, 32'h2000_0020, $urandom(), $urandom());
        chk("both_haddr", HADDR, 32'h2000_0020);
        chk("both_c_hready", 32'(C_HREADY), 32'd0);
        tick();
        drive(T_NSEQ, T_IDLE, 1'b1, 32'h0000_1200, 32'h0, $urandom(), $urandom());
        chk("both_htrans_idle", 32'(HTRANS), 32'(T_IDLE));
        tick();
        drive(T_NSEQ, T_IDLE, 1'b1, 32'h0000_1200, 32'h0, $urandom(), $urandom());
        chk("both_core_haddr", HADDR, 32'h0000_1200);
        tick();

        // Reset while the debugger owns grant and data phase.
        drive(T_IDLE, T_NSEQ, 1'b1, 32'h0, 32'h2000_0030, $urandom(), $urandom()); tick();
        drive(T_IDLE, T_NSEQ, 1'b1, 32'h0, 32'h2000_0034, $urandom(), $urandom()); tick();
        drive(T_IDLE, T_NSEQ, 1'b0, 32'h0, 32'h2000_0034, $urandom(), $urandom());
        chk("pre_rst_d_hready", 32'(D_HREADY), 32'd0);
        do_reset();

        // Random traffic, BUSY included, with rare asynchronous resets.
        for (int n = 0; n < 800; n++) begin
            case ($urandom_range(0, 7))
                0, 1, 2, 3: ct = T_IDLE;
                4:          ct = T_BUSY;
                5:          ct = T_SEQ;
                default:    ct = T_NSEQ;
            endcase
            case ($urandom_range(0, 7))
                0, 1, 2, 3: dt = T_IDLE;
                4:          dt = T_BUSY;
                5:          dt = T_SEQ;
                default:    dt = T_NSEQ;
            endcase
            drive(ct, dt, 1'($urandom_range(0, 3) != 0), $urandom(), $urandom(),
                  $urandom(), $urandom());
            if ($urandom_range(0, 99) == 0) do_reset();
            else tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
